if_fetch: RTL and testbench

//  Instruction-fetch stage; sits directly upstream of the decode stage.

---
 rtl/if_fetch.sv | 114 +++++++++++
 tb/tb_if_fetch.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction-memory
// request port, and presents pc/instr/valid to decode with stall and redirect handling.
module if_fetch #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [ADDR_W-1:0]  PC_STEP   = ADDR_W'(4),
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               stall,
  input  logic               i_redirect_en,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_KILL  = 2'd2;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  kill_pc;
  logic [ADDR_W-1:0]  buf_pc;
  logic [INSTR_W-1:0] buf_instr;
  logic [ADDR_W-1:0]  pc_p1;
  logic [INSTR_W-1:0] instr_p1;
  logic               vld_p1;
  logic               fetch_ack;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

  assign o_imem_req  = !clr && (state == S_FETCH || state == S_KILL);
  assign o_imem_addr = fetch_pc;
  // An ack while no request is outstanding (HOLD) carries nothing for us.
  assign fetch_ack   = i_imem_ack && (state != S_HOLD);

  // Stage p1: registered outputs to decode
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_FETCH;
      fetch_pc  <= RESET_PC;
      kill_pc   <= '0;
      buf_pc    <= '0;
      buf_instr <= '0;
      pc_p1     <= '0;
      instr_p1  <= NOP_INSTR;
      vld_p1    <= 1'b0;
    end else if (i_redirect_en) begin
      pc_p1    <= '0;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
      // Without an ack the in-flight address must stay put, so park the target.
      if (state == S_HOLD || fetch_ack) begin
        fetch_pc <= i_redirect_pc;
        state    <= S_FETCH;
      end else begin
        kill_pc <= i_redirect_pc;
        state   <= S_KILL;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (fetch_ack) begin
            if (!stall) begin
              pc_p1    <= fetch_pc;
              instr_p1 <= i_imem_rdata;
              vld_p1   <= 1'b1;
              fetch_pc <= pc_inc(fetch_pc);
            end else begin
              buf_pc    <= fetch_pc;
              buf_instr <= i_imem_rdata;
              state     <= S_HOLD;
            end
          end else if (!stall) begin
            pc_p1    <= '0;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc_p1    <= buf_pc;
            instr_p1 <= buf_instr;
            vld_p1   <= 1'b1;
            fetch_pc <= pc_inc(fetch_pc);
            state    <= S_FETCH;
          end
        end
        S_KILL: begin
          if (fetch_ack) begin
            fetch_pc <= kill_pc;
            state    <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign o_pc    = pc_p1;
  assign o_instr = instr_p1;
  assign o_valid = vld_p1;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus randomized traffic checked against
// a transaction-level model of the fetch stage.
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, stall, redir_en, imem_req, imem_ack, valid;
  logic [31:0] redir_pc, imem_addr, imem_rdata, pc, instr;

  logic        clr2, stall2, redir_en2, imem_req2, imem_ack2, valid2;
  logic [31:0] redir_pc2, imem_addr2, imem_rdata2, pc2, instr2;

  if_fetch dut (
    .clk(clk), .clr(clr), .stall(stall),
    .i_redirect_en(redir_en), .i_redirect_pc(redir_pc),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
    .o_pc(pc), .o_instr(instr), .o_valid(valid)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .clr(clr2), .stall(stall2),
    .i_redirect_en(redir_en2), .i_redirect_pc(redir_pc2),
    .o_imem_req(imem_req2), .o_imem_addr(imem_addr2),
    .i_imem_ack(imem_ack2), .i_imem_rdata(imem_rdata2),
    .o_pc(pc2), .o_instr(instr2), .o_valid(valid2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: next address, a pending-discard flag, a parked-instruction queue.
  logic [31:0] m_pc = '0;
  logic [31:0] m_target = '0;
  bit          m_discard = 1'b0;
  logic [31:0] q_pc[$];
  logic [31:0] q_instr[$];
  logic [31:0] e_pc, e_instr, e_addr;
  bit          e_valid, e_req;
  logic        obs_req;
  logic [31:0] obs_addr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick(input bit c, input bit s, input bit r, input logic [31:0] rp, input bit a);
    clr = c; stall = s; redir_en = r; redir_pc = rp;
    e_req  = !c && (q_pc.size() == 0);
    e_addr = m_pc;
    imem_ack   = e_req && a;
    imem_rdata = imem_ack ? mem(m_pc) : $urandom;
    #1;
    obs_req  = imem_req;
    obs_addr = imem_addr;
    @(posedge clk);
    if (c) begin
      m_pc = '0; m_discard = 1'b0; q_pc.delete(); q_instr.delete();
      e_pc = '0; e_instr = NOP; e_valid = 1'b0;
    end else if (r) begin
      e_pc = '0; e_instr = NOP; e_valid = 1'b0;
      if (q_pc.size() != 0) begin
        q_pc.delete(); q_instr.delete(); m_pc = rp;
      end else if (imem_ack) begin
        m_pc = rp; m_discard = 1'b0;
      end else begin
        m_discard = 1'b1; m_target = rp;
      end
    end else if (q_pc.size() != 0) begin
      if (!s) begin
        e_pc = q_pc.pop_front(); e_instr = q_instr.pop_front(); e_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else if (m_discard) begin
      if (imem_ack) begin m_pc = m_target; m_discard = 1'b0; end
    end else if (imem_ack) begin
      if (!s) begin
        e_pc = m_pc; e_instr = mem(m_pc); e_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else begin
        q_pc.push_back(m_pc); q_instr.push_back(mem(m_pc));
      end
    end else if (!s) begin
      e_pc = '0; e_instr = NOP; e_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1);
    n_tests++;
    if (obs_req !== 1'b0 || pc !== 32'h0 || instr !== NOP || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_req: req=%b pc=%h instr=%h valid=%b, want req=0 pc=0 instr=%h valid=0",
               obs_req, pc, instr, valid, NOP);
    end
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    n_tests++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%b addr=%h valid=%b, want req=1 addr=0 valid=0",
               obs_req, obs_addr, valid);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 1);
      n_tests++;
      if (obs_addr !== 32'(i * 4) || pc !== 32'(i * 4) || valid !== 1'b1 || instr !== mem(32'(i * 4))) begin
        n_fail++;
        $display("FAIL seq_%0d: addr=%h pc=%h valid=%b instr=%h, want addr=pc=%h valid=1 instr=%h",
                 i, obs_addr, pc, valid, instr, 32'(i * 4), mem(32'(i * 4)));
      end
    end
  endtask

  task automatic test_ack_wait();
    do_reset();
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0);
      n_tests++;
      if (obs_req !== 1'b1 || obs_addr !== 32'h8 || valid !== 1'b0 || instr !== NOP) begin
        n_fail++;
        $display("FAIL wait_bubble_%0d: req=%b addr=%h valid=%b instr=%h, want req=1 addr=8 valid=0 instr=%h",
                 i, obs_req, obs_addr, valid, instr, NOP);
      end
    end
    tick(0, 0, 0, 0, 1);
    n_tests++;
    if (pc !== 32'h8 || valid !== 1'b1 || instr !== mem(32'h8)) begin
      n_fail++;
      $display("FAIL wait_resume: pc=%h valid=%b instr=%h, want pc=8 valid=1 instr=%h",
               pc, valid, instr, mem(32'h8));
    end
  endtask

  task automatic test_stall_buffer();
    do_reset();
    tick(0, 0, 0, 0, 1);
    tick(0, 1, 0, 0, 1);
    n_tests++;
    if (pc !== 32'h0 || valid !== 1'b1 || instr !== mem(32'h0)) begin
      n_fail++;
      $display("FAIL stall_hold: pc=%h valid=%b instr=%h, want pc=0 valid=1 instr=%h",
               pc, valid, instr, mem(32'h0));
    end
    tick(0, 1, 0, 0, 1);
    n_tests++;
    if (obs_req !== 1'b0 || pc !== 32'h0 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_req_drop: req=%b pc=%h valid=%b, want req=0 pc=0 valid=1",
               obs_req, pc, valid);
    end
    tick(0, 0, 0, 0, 1);
    n_tests++;
    if (pc !== 32'h4 || valid !== 1'b1 || instr !== mem(32'h4)) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h valid=%b instr=%h, want pc=4 valid=1 instr=%h",
               pc, valid, instr, mem(32'h4));
    end
    tick(0, 0, 0, 0, 1);
    n_tests++;
    if (obs_addr !== 32'h8 || pc !== 32'h8 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_next: addr=%h pc=%h valid=%b, want addr=8 pc=8 valid=1", obs_addr, pc, valid);
    end
  endtask

  task automatic test_redirect_kill();
    do_reset();
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1);
    tick(0, 0, 1, 32'h100, 0);
    n_tests++;
    if (obs_addr !== 32'h10 || valid !== 1'b0 || instr !== NOP || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL kill_flush: addr=%h valid=%b instr=%h pc=%h, want addr=10 valid=0 NOP pc=0",
               obs_addr, valid, instr, pc);
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    n_tests++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h10 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_discard: req=%b addr=%h valid=%b, want req=1 addr=10 valid=0",
               obs_req, obs_addr, valid);
    end
    tick(0, 0, 0, 0, 1);
    n_tests++;
    if (obs_addr !== 32'h100 || pc !== 32'h100 || valid !== 1'b1 || instr !== mem(32'h100)) begin
      n_fail++;
      $display("FAIL kill_target: addr=%h pc=%h valid=%b, want addr=100 pc=100 valid=1",
               obs_addr, pc, valid);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    tick(0, 0, 0, 0, 1);
    tick(0, 1, 1, 32'h40, 1);
    n_tests++;
    if (valid !== 1'b0 || instr !== NOP) begin
      n_fail++;
      $display("FAIL redir_stall_flush: valid=%b instr=%h, want valid=0 instr=%h", valid, instr, NOP);
    end
    tick(0, 0, 0, 0, 1);
    n_tests++;
    if (obs_addr !== 32'h40 || pc !== 32'h40 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_stall_resume: addr=%h pc=%h valid=%b, want addr=40 pc=40 valid=1",
               obs_addr, pc, valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] rp;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0003_FFFF);
      tick($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, rp, $urandom_range(0, 3) != 0);
      n_tests++;
      if (obs_req !== e_req || (e_req && obs_addr !== e_addr)) begin
        n_fail++;
        $display("FAIL rand_req_%0d: req=%b addr=%h, want req=%b addr=%h", i, obs_req, obs_addr, e_req, e_addr);
      end
      n_tests++;
      if (pc !== e_pc || instr !== e_instr || valid !== e_valid) begin
        n_fail++;
        $display("FAIL rand_out_%0d: pc=%h instr=%h valid=%b, want pc=%h instr=%h valid=%b",
                 i, pc, instr, valid, e_pc, e_instr, e_valid);
      end
    end
  endtask

  task automatic test_wrap();
    clr2 = 1'b1; imem_ack2 = 1'b0;
    @(posedge clk); #1;
    clr2 = 1'b0; imem_ack2 = 1'b1; imem_rdata2 = 32'hAAAA_0001;
    #1;
    n_tests++;
    if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_first: req=%b addr=%h, want req=1 addr=fffffffc", imem_req2, imem_addr2);
    end
    @(posedge clk); #1;
    imem_rdata2 = 32'hAAAA_0002;
    #1;
    n_tests++;
    if (pc2 !== 32'hFFFF_FFFC || valid2 !== 1'b1 || instr2 !== 32'hAAAA_0001 || imem_addr2 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_second: pc=%h valid=%b instr=%h addr=%h, want pc=fffffffc valid=1 instr=aaaa0001 addr=0",
               pc2, valid2, instr2, imem_addr2);
    end
    @(posedge clk); #1;
    imem_ack2 = 1'b0;
    clr2 = 1'b1;
    #1;
    n_tests++;
    if (pc2 !== 32'h0 || instr2 !== 32'hAAAA_0002 || imem_req2 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_clr_req: pc=%h instr=%h req=%b, want pc=0 instr=aaaa0002 req=0", pc2, instr2, imem_req2);
    end
    @(posedge clk); #1;
    clr2 = 1'b0;
    #1;
    n_tests++;
    if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC || valid2 !== 1'b0 || pc2 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_after_clr: req=%b addr=%h valid=%b pc=%h, want req=1 addr=fffffffc valid=0 pc=0",
               imem_req2, imem_addr2, valid2, pc2);
    end
  endtask

  initial begin
    clr = 1'b1; stall = 1'b0; redir_en = 1'b0; redir_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
    clr2 = 1'b1; stall2 = 1'b0; redir_en2 = 1'b0; redir_pc2 = '0; imem_ack2 = 1'b0; imem_rdata2 = '0;
    test_reset();
    test_sequential();
    test_ack_wait();
    test_stall_buffer();
    test_redirect_kill();
    test_redirect_stall();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
